// File: rtl/vga_game_pkg.sv
// Shared constants, FSM encoding and colour helper for the VGA game blocks.
package vga_game_pkg;

    localparam int STEP_DEF    = 32;
    localparam int X_MAX_DEF   = 256;
    localparam int Y_MAX_DEF   = 96;
    localparam int X_SPAWN_DEF = 128;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LAND  = 2'd1,
        ST_SPAWN = 2'd2
    } mover_state_e;

    // Colour walks 001..111 and wraps back to 001, never emitting black.
    function automatic logic [2:0] next_colour(input logic [2:0] colour);
        logic [2:0] result;
        if (colour == 3'b111) begin
            result = 3'b001;
        end else begin
            result = colour + 3'b001;
        end
        return result;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw button.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic btn_raw,
    output logic btn_level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;

    // Synchronize the raw input, then follow it only after a full run of differing samples.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync_r  <= 2'b00;
            cnt_r   <= '0;
            level_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], btn_raw};
            if (sync_r[1] == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                level_r <= sync_r[1];
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign btn_level = level_r;

endmodule

// File: rtl/piece_mover.sv
// Moves the falling piece on frame ticks from debounced button requests.
// Optional gravity is enabled by defining PIECE_MOVER_GRAVITY_EN.
module piece_mover
    import vga_game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int STEP            = STEP_DEF,
    parameter int X_MAX           = X_MAX_DEF,
    parameter int Y_MAX           = Y_MAX_DEF,
    parameter int X_SPAWN         = X_SPAWN_DEF,
    parameter int FALL_FRAMES     = 30
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iVsync,
    input  logic       iBtnLeft,
    input  logic       iBtnRight,
    input  logic       iBtnDown,
    output logic [9:0] oXRedCounter,
    output logic [9:0] oYRedCounter,
    output logic [2:0] oColorCuadro,
    output logic       oLanded
);

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_D = 2;

    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [9:0]  STEP_N    = 10'(STEP);
    localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
    localparam logic [10:0] Y_MAX_W   = 11'(Y_MAX);
    localparam logic [9:0]  X_SPAWN_N = 10'(X_SPAWN);

    logic [2:0]   raw_s;
    logic [2:0]   level_s;
    logic [2:0]   level_d_r;
    logic [2:0]   rise_s;
    logic [2:0]   req_r;
    logic         vsync_d_r;
    logic         tick_r;
    logic         consume_s;
    logic         grav_s;

    mover_state_e state_r, state_nxt_s;
    logic [9:0]   x_r, x_nxt_s;
    logic [9:0]   y_r, y_nxt_s;
    logic [2:0]   colour_r, colour_nxt_s;
    logic         landed_r;

    logic [10:0]  x_add_s;
    logic [10:0]  y_add_s;

    assign raw_s = {iBtnDown, iBtnRight, iBtnLeft};

    for (genvar i = 0; i < 3; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .Clock    (Clock),
            .Reset    (Reset),
            .btn_raw  (raw_s[i]),
            .btn_level(level_s[i])
        );
    end

    assign rise_s    = level_s & ~level_d_r;
    assign consume_s = tick_r && (state_r == ST_RUN);
    assign x_add_s   = {1'b0, x_r} + STEP_W;
    assign y_add_s   = {1'b0, y_r} + STEP_W;

`ifdef PIECE_MOVER_GRAVITY_EN
    localparam logic [15:0] FALL_LAST = 16'(FALL_FRAMES - 1);
    logic [15:0] frame_cnt_r;

    assign grav_s = consume_s && (frame_cnt_r == FALL_LAST);

    // Count RUN ticks; wrap on the gravity tick and restart with each new piece.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            frame_cnt_r <= 16'd0;
        end else if (state_r == ST_SPAWN) begin
            frame_cnt_r <= 16'd0;
        end else if (grav_s) begin
            frame_cnt_r <= 16'd0;
        end else if (consume_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end
`else
    assign grav_s = 1'b0;
`endif

    // Vsync falling-edge tick and sticky requests; a fresh press beats same-cycle consumption.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            vsync_d_r <= 1'b1;
            tick_r    <= 1'b0;
            level_d_r <= 3'b000;
            req_r     <= 3'b000;
        end else begin
            vsync_d_r <= iVsync;
            tick_r    <= vsync_d_r & ~iVsync;
            level_d_r <= level_s;
            req_r     <= (req_r & ~{3{consume_s}}) | rise_s;
        end
    end

    // Next piece position, colour and FSM state.
    always_comb begin
        state_nxt_s  = state_r;
        x_nxt_s      = x_r;
        y_nxt_s      = y_r;
        colour_nxt_s = colour_r;
        case (state_r)
            ST_RUN: begin
                if (consume_s) begin
                    if (req_r[BTN_L] && !req_r[BTN_R]) begin
                        if (x_r >= STEP_N) begin
                            x_nxt_s = x_r - STEP_N;
                        end else begin
                            x_nxt_s = x_r;
                        end
                    end else if (req_r[BTN_R] && !req_r[BTN_L]) begin
                        if (x_add_s <= X_MAX_W) begin
                            x_nxt_s = x_add_s[9:0];
                        end else begin
                            x_nxt_s = x_r;
                        end
                    end else begin
                        x_nxt_s = x_r;
                    end
                    // Request and gravity are merged so they can only ever give one step.
                    if (req_r[BTN_D] || grav_s) begin
                        if (y_add_s <= Y_MAX_W) begin
                            y_nxt_s = y_add_s[9:0];
                        end else begin
                            state_nxt_s = ST_LAND;
                        end
                    end else begin
                        y_nxt_s = y_r;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LAND: begin
                state_nxt_s = ST_SPAWN;
            end
            ST_SPAWN: begin
                state_nxt_s  = ST_RUN;
                x_nxt_s      = X_SPAWN_N;
                y_nxt_s      = 10'd0;
                colour_nxt_s = next_colour(colour_r);
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r  <= ST_RUN;
            x_r      <= X_SPAWN_N;
            y_r      <= 10'd0;
            colour_r <= 3'b001;
            landed_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            x_r      <= x_nxt_s;
            y_r      <= y_nxt_s;
            colour_r <= colour_nxt_s;
            landed_r <= (state_nxt_s == ST_LAND);
        end
    end

    assign oXRedCounter = x_r;
    assign oYRedCounter = y_r;
    assign oColorCuadro = colour_r;
    assign oLanded      = landed_r;

endmodule

// File: doc/piece_mover.md
PIECE_MOVER -- requirements
Module: piece_mover

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, clocks a raw button level must stay stable before the debounced level follows it.
REQ-002 Parameter STEP, default 32, pixel step per move.
REQ-003 Parameter X_MAX, default 256, and Y_MAX, default 96: inclusive upper bounds of the X and Y offsets.
REQ-004 Parameter X_SPAWN, default 128, X offset after reset and after each spawn.
REQ-005 Parameter FALL_FRAMES, default 30, frames per gravity step.
REQ-006 One clock; reset is asynchronous and active-low. Ports: Clock  in  1  pixel clock; Reset  in  1  asynchronous active-low reset.
REQ-007 iVsync  in  1  vertical sync from the VGA controller, same clock domain, active-low pulse.
REQ-008 iBtnLeft, iBtnRight, iBtnDown  in  1 each  raw asynchronous push-buttons, active-high.
REQ-009 oXRedCounter  out  10  piece X offset; oYRedCounter  out  10  piece Y offset.
REQ-010 oColorCuadro  out  3  piece colour; oLanded  out  1  one-cycle landing pulse.

Function
REQ-011 Each button SHALL pass through a two-flop synchronizer, then a debouncer that updates its level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-012 A rising edge of a debounced level SHALL set that button's sticky request flag.
REQ-013 Frame tick SHALL be a one-cycle pulse on the clock after iVsync is seen falling (registered edge detect).
REQ-014 FSM states RUN, LAND, SPAWN; moves are applied only on a frame tick in RUN, and every request flag is cleared when consumed.
REQ-015 Left: X -= STEP if X >= STEP, else X holds. Right: X += STEP if X + STEP <= X_MAX, else X holds. A blocked move still clears its flag.
REQ-016 When left and right are both pending at the same tick, X SHALL hold and both flags SHALL clear.
REQ-017 Down (request or gravity): Y += STEP if Y + STEP <= Y_MAX; otherwise the FSM SHALL go to LAND and Y holds.
REQ-018 A down request and a gravity step at the same tick SHALL produce exactly one step.
REQ-019 LAND SHALL last one cycle with oLanded=1. SPAWN SHALL last one cycle, setting X=X_SPAWN, Y=0 and advancing colour 001->...->111->001 (000 never output), then return to RUN.
REQ-020 Requests arriving during LAND or SPAWN SHALL remain pending until the next RUN tick.
REQ-021 Outputs SHALL be registered and update on the clock after the frame tick (latency 1).
REQ-022 Arithmetic SHALL be 10-bit unsigned; bound checks SHALL use an 11-bit sum so they cannot wrap.

Reset
REQ-023 Reset low SHALL immediately force X=X_SPAWN, Y=0, oColorCuadro=3'b001, oLanded=0, state RUN, all flags, counters and debounced levels to 0.
REQ-024 Reset asserted mid-move or in LAND/SPAWN SHALL discard all pending requests; the first tick after release SHALL see no stale request.

Configuration
REQ-025 With macro PIECE_MOVER_GRAVITY_EN defined, a frame counter SHALL issue a gravity down step on every FALL_FRAMES-th tick in RUN; the counter clears on SPAWN.
REQ-026 Without PIECE_MOVER_GRAVITY_EN, no gravity logic SHALL exist and Y changes only on button down.

Structure
REQ-027 STEP, X_MAX, Y_MAX, X_SPAWN and the state encodings SHALL live in shared package vga_game_pkg.
REQ-028 Synchronizer plus debouncer SHALL be sub-module button_debouncer, instantiated three times.

Verification
REQ-029 DEBOUNCE_CYCLES=4. Left pulse of 2 clocks (glitch) -> no X change. Held 10 clocks -> X 128->96 one clock after the next tick.
REQ-030 X=0 plus left -> X stays 0 and the flag clears. X=256 plus right -> X stays 256.
REQ-031 Left and right pressed before the same tick -> X unchanged; the following tick with no press -> X unchanged.
REQ-032 Y=96 plus down -> oLanded high exactly 1 cycle, then X=128, Y=0, colour 001->010. Seven landings from 111 -> 001.
REQ-033 GRAVITY_EN, FALL_FRAMES=3 -> Y +32 every 3rd tick. Down pressed on a gravity tick -> single +32.
REQ-034 Reset asserted between a press and its tick -> outputs at reset values immediately; no move after release.
